bus_decoder: RTL and testbench
==============================

BUS_DECODER -- requirements
Module: bus_decoder

Interface
REQ-001 SHALL have parameter N_DEV, default 6: number of attached memory-mapped devices, range 1..16.
REQ-002 SHALL have parameter READ_LATENCY, default 1: cycles from address to read data, range 1..3.
REQ-003 SHALL have parameter DEV_MAP, default common::DEFAULT_DEV_MAP: per-device {base, mask} address window table, indexed 0..N_DEV-1.
REQ-004 SHALL have ports (one per line):
- clk_i  input  1  CPU clock.
- reset_i  input  1  asynchronous, active-low reset.
- addr_i  input  32  data-bus address.
- read_en_i  input  1  read request this cycle.
- write_mask_i  input  4  byte write strobes; nonzero = write.
- dev_write_mask_o  output  N_DEV x 4  per-device gated write strobes.
- dev_read_data_i  input  N_DEV x 32  per-device read data, valid READ_LATENCY cycles after address.
- read_data_o  output  32  selected read data.
- read_valid_o  output  1  read_data_o corresponds to a read issued READ_LATENCY cycles earlier.
- fault_clear_i  input  1  clears fault capture state.
- fault_o  output  1  sticky: unmapped access seen.
- fault_addr_o  output  32  address of first unmapped access since clear.
- fault_write_o  output  1  first unmapped access was a write.
- fault_count_o  output  16  saturating count of unmapped accesses.

Function
REQ-005 SHALL declare device i hit when (addr_i & DEV_MAP[i].mask) == DEV_MAP[i].base.
REQ-006 SHALL resolve overlapping windows by lowest index winning; at most one device selected.
REQ-007 SHALL drive dev_write_mask_o[i] = write_mask_i combinationally (zero latency) for the selected device, 4'b0000 for all others.
REQ-008 SHALL define an access as read_en_i=1 or write_mask_i!=0; no-access cycles SHALL have no effect on pipeline contents beyond shifting a valid=0 entry.
REQ-009 SHALL carry {read valid, hit, selected index} through a READ_LATENCY-deep register pipeline.
REQ-010 SHALL drive read_data_o = dev_read_data_i[index] at the pipeline tail when valid and hit; 32'h0 otherwise (including unmapped reads).
REQ-011 SHALL assert read_valid_o for exactly one cycle, READ_LATENCY cycles after each read, mapped or unmapped; back-to-back reads SHALL yield back-to-back valids.
REQ-012 SHALL treat an access matching no window as unmapped.
REQ-013 SHALL, on an unmapped access with fault_o=0, set fault_o, latch fault_addr_o=addr_i and fault_write_o=(write_mask_i!=0) on the next edge.
REQ-014 SHALL NOT overwrite fault_addr_o/fault_write_o while fault_o=1.
REQ-015 SHALL increment fault_count_o by 1 per unmapped access, saturating at 16'hFFFF.
REQ-016 SHALL, on fault_clear_i=1, zero fault_o, fault_addr_o, fault_write_o, fault_count_o next edge.
REQ-017 SHALL, on fault_clear_i coinciding with an unmapped access, let the new fault win: fault_o=1, address/flag latched from that access, fault_count_o=1.
REQ-018 SHALL flag simultaneous read and write as write (fault_write_o=1) and count it once.

Reset
REQ-019 SHALL, while reset_i=0, clear pipeline valids, fault_o, fault_addr_o, fault_write_o, fault_count_o to 0; read_data_o=0, read_valid_o=0.
REQ-020 SHALL discard reads in flight at reset; no read_valid_o pulse after release for pre-reset reads.
REQ-021 SHALL keep dev_write_mask_o combinational and unaffected by reset state.

Structure
REQ-022 SHALL place dev_range_t {base, mask : word_t}, MAX_DEV=16 and DEFAULT_DEV_MAP (BIOS 0x0/0xF0000000, RAM 0x1/0xF0000000, VRAM 0x2/0xF0000000, display 0xFF000000/0xFFFFFFFF, switches 0xFF000004/0xFFFFFFFF, keyboard 0xFF000008/0xFFFFFFFF) in package common.
REQ-023 SHALL implement fault capture (REQ-013..018) in one sub-module, bus_fault_capture.

Verification
REQ-024 Read 0x10000040, READ_LATENCY=1, RAM data 0xDEADBEEF -> read_data_o=0xDEADBEEF, read_valid_o=1 one cycle later.
REQ-025 Write mask 4'b0011 to 0x20000010 -> dev_write_mask_o[2]=4'b0011 same cycle, all others 0.
REQ-026 READ_LATENCY=3, reads to 0x0, 0x1000_0000, 0xFF000004 on consecutive cycles -> three consecutive valids, data in order, cycles 3..5.
REQ-027 Read 0x40000000, then write 0x50000000 -> fault_addr_o=0x40000000, fault_write_o=0, fault_count_o=2, read_data_o=0 with valid.
REQ-028 fault_clear_i with write to 0x30000000 same cycle -> fault_o=1, fault_addr_o=0x30000000, fault_write_o=1, fault_count_o=1; 65536 unmapped accesses -> count holds 0xFFFF.
REQ-029 reset_i low with two reads in flight -> outputs 0 during reset, no read_valid_o after release.

Source files
------------

// File: rtl/bus_decoder_pkg.sv
// Shared address-map types and the default device window table for the CPU data bus.
// Windows match when (addr & mask) == base; unused table slots never match.
package common;

   typedef logic [31:0] word_t;

   typedef struct packed {
      word_t base;
      word_t mask;
   } dev_range_t;

   localparam int MAX_DEV = 16;

   typedef dev_range_t [MAX_DEV-1:0] dev_map_t;

   function automatic dev_map_t default_dev_map();
      dev_map_t m;
      // base with bits outside a zero mask can never match, so spare slots stay dead
      for (int i = 0; i < MAX_DEV; i++) begin
         m[i].base = 32'hFFFF_FFFF;
         m[i].mask = 32'h0000_0000;
      end
      m[0] = '{base: 32'h0000_0000, mask: 32'hF000_0000};  // BIOS
      m[1] = '{base: 32'h1000_0000, mask: 32'hF000_0000};  // RAM
      m[2] = '{base: 32'h2000_0000, mask: 32'hF000_0000};  // VRAM
      m[3] = '{base: 32'hFF00_0000, mask: 32'hFFFF_FFFF};  // display
      m[4] = '{base: 32'hFF00_0004, mask: 32'hFFFF_FFFF};  // switches
      m[5] = '{base: 32'hFF00_0008, mask: 32'hFFFF_FFFF};  // keyboard
      return m;
   endfunction

   localparam dev_map_t DEFAULT_DEV_MAP = default_dev_map();

endpackage

// File: rtl/bus_fault_capture.sv
// Sticky capture of the first unmapped bus access plus a saturating unmapped-access counter.
module bus_fault_capture
   import common::*;
(
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        unmapped_i,
   input  logic        is_write_i,
   input  word_t       addr_i,
   input  logic        fault_clear_i,
   output logic        fault_o,
   output word_t       fault_addr_o,
   output logic        fault_write_o,
   output logic [15:0] fault_count_o
);

   logic        r_fault;
   word_t       r_addr;
   logic        r_write;
   logic [15:0] r_count;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_fault <= 1'b0;
         r_addr  <= '0;
         r_write <= 1'b0;
         r_count <= '0;
      end else if (unmapped_i) begin
         // a clear in the same cycle loses to the new fault
         if (!r_fault || fault_clear_i) begin
            r_fault <= 1'b1;
            r_addr  <= addr_i;
            r_write <= is_write_i;
         end
         if (fault_clear_i)
            r_count <= 16'd1;
         else if (r_count != 16'hFFFF)
            r_count <= r_count + 16'd1;
      end else if (fault_clear_i) begin
         r_fault <= 1'b0;
         r_addr  <= '0;
         r_write <= 1'b0;
         r_count <= '0;
      end
   end

   assign fault_o       = r_fault;
   assign fault_addr_o  = r_addr;
   assign fault_write_o = r_write;
   assign fault_count_o = r_count;

endmodule

// File: rtl/bus_decoder.sv
// Memory-mapped bus decoder: window match, zero-latency write strobe steering,
// READ_LATENCY-deep read-return mux and unmapped-access fault capture.
module bus_decoder
   import common::*;
#(
   parameter int       N_DEV        = 6,
   parameter int       READ_LATENCY = 1,
   parameter dev_map_t DEV_MAP      = DEFAULT_DEV_MAP
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic [31:0]            addr_i,
   input  logic                   read_en_i,
   input  logic [3:0]             write_mask_i,
   output logic [N_DEV-1:0][3:0]  dev_write_mask_o,
   input  logic [N_DEV-1:0][31:0] dev_read_data_i,
   output logic [31:0]            read_data_o,
   output logic                   read_valid_o,
   input  logic                   fault_clear_i,
   output logic                   fault_o,
   output logic [31:0]            fault_addr_o,
   output logic                   fault_write_o,
   output logic [15:0]            fault_count_o
);

   localparam int IDX_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;

   logic             w_hit;
   logic [IDX_W-1:0] w_idx;
   logic             w_is_write;
   logic             w_unmapped;

   // scan high to low so the lowest matching index is the one left standing
   always_comb begin
      w_hit = 1'b0;
      w_idx = '0;
      for (int i = N_DEV-1; i >= 0; i--) begin
         if ((addr_i & DEV_MAP[i].mask) == DEV_MAP[i].base) begin
            w_hit = 1'b1;
            w_idx = i[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < N_DEV; i++)
         dev_write_mask_o[i] = (w_hit && (w_idx == i[IDX_W-1:0])) ? write_mask_i : 4'b0000;
   end

   assign w_is_write = |write_mask_i;
   assign w_unmapped = (read_en_i || w_is_write) && !w_hit;

   logic [READ_LATENCY-1:0]            r_vld_pipe;
   logic [READ_LATENCY-1:0]            r_hit_pipe;
   logic [READ_LATENCY-1:0][IDX_W-1:0] r_idx_pipe;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_vld_pipe <= '0;
         r_hit_pipe <= '0;
         r_idx_pipe <= '0;
      end else begin
         r_vld_pipe[0] <= read_en_i;
         r_hit_pipe[0] <= read_en_i && w_hit;
         r_idx_pipe[0] <= read_en_i ? w_idx : '0;
         for (int s = 1; s < READ_LATENCY; s++) begin
            r_vld_pipe[s] <= r_vld_pipe[s-1];
            r_hit_pipe[s] <= r_hit_pipe[s-1];
            r_idx_pipe[s] <= r_idx_pipe[s-1];
         end
      end
   end

   logic             w_tail_vld;
   logic             w_tail_hit;
   logic [IDX_W-1:0] w_tail_idx;

   assign w_tail_vld = r_vld_pipe[READ_LATENCY-1];
   assign w_tail_hit = r_hit_pipe[READ_LATENCY-1];
   assign w_tail_idx = r_idx_pipe[READ_LATENCY-1];

   // unmapped reads still pulse valid, but with zero data
   always_comb begin
      read_data_o = '0;
      for (int i = 0; i < N_DEV; i++)
         if (w_tail_vld && w_tail_hit && (w_tail_idx == i[IDX_W-1:0]))
            read_data_o = dev_read_data_i[i];
   end

   assign read_valid_o = w_tail_vld;

   bus_fault_capture u_fault (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .unmapped_i    (w_unmapped),
      .is_write_i    (w_is_write),
      .addr_i        (addr_i),
      .fault_clear_i (fault_clear_i),
      .fault_o       (fault_o),
      .fault_addr_o  (fault_addr_o),
      .fault_write_o (fault_write_o),
      .fault_count_o (fault_count_o)
   );

endmodule

// File: tb/tb_bus_decoder.sv
// Self-checking bench for bus_decoder: two instances (read latency 1 and 3) share stimulus;
// read returns are checked against a scoreboard of expected {due cycle, data}.
module tb_bus_decoder;

   logic clk = 1'b0;
   logic reset_i;
   logic [31:0] addr;
   logic rd;
   logic [3:0] wm;
   logic clr;
   logic [5:0][31:0] dev_rd;

   logic [5:0][3:0] wm1, wm3;
   logic [31:0] rdata1, rdata3, fa1, fa3;
   logic rvld1, rvld3, f1, f3, fw1, fw3;
   logic [15:0] fc1, fc3;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      int          due;
      logic [31:0] data;
   } exp_t;
   exp_t q1[$];
   exp_t q3[$];

   logic [31:0] m_base [6] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000,
                               32'hFF00_0000, 32'hFF00_0004, 32'hFF00_0008};
   logic [31:0] m_mask [6] = '{32'hF000_0000, 32'hF000_0000, 32'hF000_0000,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

   bus_decoder #(.N_DEV(6), .READ_LATENCY(1)) u1 (
      .clk_i(clk), .reset_i(reset_i), .addr_i(addr), .read_en_i(rd), .write_mask_i(wm),
      .dev_write_mask_o(wm1), .dev_read_data_i(dev_rd), .read_data_o(rdata1),
      .read_valid_o(rvld1), .fault_clear_i(clr), .fault_o(f1), .fault_addr_o(fa1),
      .fault_write_o(fw1), .fault_count_o(fc1));

   bus_decoder #(.N_DEV(6), .READ_LATENCY(3)) u3 (
      .clk_i(clk), .reset_i(reset_i), .addr_i(addr), .read_en_i(rd), .write_mask_i(wm),
      .dev_write_mask_o(wm3), .dev_read_data_i(dev_rd), .read_data_o(rdata3),
      .read_valid_o(rvld3), .fault_clear_i(clr), .fault_o(f3), .fault_addr_o(fa3),
      .fault_write_o(fw3), .fault_count_o(fc3));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic void model(input logic [31:0] a, output logic hit, output int idx);
      hit = 1'b0;
      idx = 0;
      for (int i = 0; i < 6; i++)
         if (!hit && ((a & m_mask[i]) == m_base[i])) begin
            hit = 1'b1;
            idx = i;
         end
   endfunction

   task automatic drive(input logic [31:0] a, input logic r, input logic [3:0] w,
                        input logic c = 1'b0);
      logic h;
      int   ix;
      logic [31:0] d;
      @(posedge clk);
      #1;
      addr = a; rd = r; wm = w; clr = c;
      if (r) begin
         model(a, h, ix);
         d = h ? dev_rd[ix] : 32'h0;
         q1.push_back('{cyc + 1, d});
         q3.push_back('{cyc + 3, d});
      end
   endtask

   // scoreboard monitors, sampled away from the active edge
   always @(negedge clk) begin
      if (!reset_i) begin
         q1.delete();
      end else begin
         if (q1.size() > 0 && q1[0].due < cyc) begin
            checks++; errors++;
            $display("FAIL lat1_missing_valid: no valid seen, required one at cycle %0d data %h", q1[0].due, q1[0].data);
            void'(q1.pop_front());
         end
         if (rvld1) begin
            checks++;
            if (q1.size() == 0) begin
               errors++;
               $display("FAIL lat1_spurious_valid: valid at cycle %0d data %h, required none", cyc, rdata1);
            end else if (q1[0].due != cyc || rdata1 !== q1[0].data) begin
               errors++;
               $display("FAIL lat1_read: cycle %0d data %h, required cycle %0d data %h", cyc, rdata1, q1[0].due, q1[0].data);
               void'(q1.pop_front());
            end else
               void'(q1.pop_front());
         end else if (rdata1 !== 32'h0) begin
            checks++; errors++;
            $display("FAIL lat1_idle_data: data %h without valid, required 0", rdata1);
         end
      end
   end

   always @(negedge clk) begin
      if (!reset_i) begin
         q3.delete();
      end else begin
         if (q3.size() > 0 && q3[0].due < cyc) begin
            checks++; errors++;
            $display("FAIL lat3_missing_valid: no valid seen, required one at cycle %0d data %h", q3[0].due, q3[0].data);
            void'(q3.pop_front());
         end
         if (rvld3) begin
            checks++;
            if (q3.size() == 0) begin
               errors++;
               $display("FAIL lat3_spurious_valid: valid at cycle %0d data %h, required none", cyc, rdata3);
            end else if (q3[0].due != cyc || rdata3 !== q3[0].data) begin
               errors++;
               $display("FAIL lat3_read: cycle %0d data %h, required cycle %0d data %h", cyc, rdata3, q3[0].due, q3[0].data);
               void'(q3.pop_front());
            end else
               void'(q3.pop_front());
         end else if (rdata3 !== 32'h0) begin
            checks++; errors++;
            $display("FAIL lat3_idle_data: data %h without valid, required 0", rdata3);
         end
      end
   end

   task automatic test_reset();
      logic [5:0][3:0] e;
      drive(32'hFF00_0000, 1'b0, 4'hF);
      #1;
      e = '0;
      e[3] = 4'hF;
      checks++;
      if (wm1 !== e) begin
         errors++;
         $display("FAIL reset_wmask: got %h, required %h", wm1, e);
      end
      checks++;
      if ({rvld1, rdata1, f1, fa1, fw1, fc1} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: vld %b data %h fault %b addr %h wr %b cnt %h, required all 0",
                  rvld1, rdata1, f1, fa1, fw1, fc1);
      end
      drive(32'h0, 1'b0, 4'h0);
      reset_i = 1'b1;
   endtask

   task automatic test_read_lat1();
      drive(32'h1000_0040, 1'b1, 4'h0);
      checks++;
      if (rvld1 !== 1'b0) begin
         errors++;
         $display("FAIL read_early_valid: got %b, required 0", rvld1);
      end
      drive(32'h0, 1'b0, 4'h0);
      checks++;
      if (rvld1 !== 1'b1 || rdata1 !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL read_ram: vld %b data %h, required 1 deadbeef", rvld1, rdata1);
      end
      drive(32'h0, 1'b0, 4'h0);
   endtask

   task automatic test_write_mask();
      logic [31:0] ta [4] = '{32'h2000_0010, 32'hFF00_0008, 32'h0FFF_FFFF, 32'hFF00_000C};
      logic [3:0]  tw [4] = '{4'b0011, 4'b1111, 4'b0100, 4'b1000};
      logic [5:0][3:0] e;
      logic h;
      int ix;
      for (int k = 0; k < 4; k++) begin
         drive(ta[k], 1'b0, tw[k]);
         #1;
         model(ta[k], h, ix);
         e = '0;
         if (h) e[ix] = tw[k];
         checks++;
         if (wm1 !== e || wm3 !== e) begin
            errors++;
            $display("FAIL write_mask[%0d]: addr %h got %h, required %h", k, ta[k], wm1, e);
         end
      end
      drive(32'h0, 1'b0, 4'h0);
   endtask

   task automatic test_back_to_back();
      logic [4:0] pat;
      drive(32'h0000_0000, 1'b1, 4'h0);
      drive(32'h1000_0000, 1'b1, 4'h0);
      drive(32'hFF00_0004, 1'b1, 4'h0);
      @(negedge clk);
      pat[0] = rvld3;
      drive(32'h0, 1'b0, 4'h0);
      for (int k = 1; k < 5; k++) begin
         @(negedge clk);
         pat[k] = rvld3;
      end
      checks++;
      if (pat !== 5'b01110) begin
         errors++;
         $display("FAIL b2b_valid_pattern: offsets 2..6 got %b, required 01110", pat);
      end
   endtask

   task automatic test_unmapped();
      drive(32'h0, 1'b0, 4'h0, 1'b1);
      drive(32'h4000_0000, 1'b1, 4'h0);
      drive(32'h5000_0000, 1'b0, 4'hF);
      checks++;
      if (rvld1 !== 1'b1 || rdata1 !== 32'h0) begin
         errors++;
         $display("FAIL unmapped_read: vld %b data %h, required 1 0", rvld1, rdata1);
      end
      drive(32'h0, 1'b0, 4'h0);
      checks++;
      if (f1 !== 1'b1 || fa1 !== 32'h4000_0000 || fw1 !== 1'b0 || fc1 !== 16'd2) begin
         errors++;
         $display("FAIL unmapped_capture: fault %b addr %h wr %b cnt %0d, required 1 40000000 0 2",
                  f1, fa1, fw1, fc1);
      end
      drive(32'h0, 1'b0, 4'h0, 1'b1);
      drive(32'h0, 1'b0, 4'h0);
      checks++;
      if ({f1, fa1, fw1, fc1} !== '0) begin
         errors++;
         $display("FAIL fault_clear: fault %b addr %h wr %b cnt %0d, required all 0", f1, fa1, fw1, fc1);
      end
      drive(32'h6000_0000, 1'b1, 4'b0001);
      drive(32'h0, 1'b0, 4'h0);
      checks++;
      if (f1 !== 1'b1 || fa1 !== 32'h6000_0000 || fw1 !== 1'b1 || fc1 !== 16'd1) begin
         errors++;
         $display("FAIL read_write_fault: fault %b addr %h wr %b cnt %0d, required 1 60000000 1 1",
                  f1, fa1, fw1, fc1);
      end
   endtask

   task automatic test_clear_collision();
      drive(32'h3000_0000, 1'b0, 4'hF, 1'b1);
      drive(32'h0, 1'b0, 4'h0);
      checks++;
      if (f1 !== 1'b1 || fa1 !== 32'h3000_0000 || fw1 !== 1'b1 || fc1 !== 16'd1) begin
         errors++;
         $display("FAIL clear_collision: fault %b addr %h wr %b cnt %0d, required 1 30000000 1 1",
                  f1, fa1, fw1, fc1);
      end
      drive(32'h0, 1'b0, 4'h0, 1'b1);
      for (int n = 1; n <= 65536; n++) begin
         drive(32'h7000_0000, 1'b0, 4'b0001);
         if (n == 65535) begin
            checks++;
            if (fc1 !== 16'hFFFE) begin
               errors++;
               $display("FAIL count_pre_sat: got %h, required fffe", fc1);
            end
         end
      end
      drive(32'h0, 1'b0, 4'h0);
      checks++;
      if (fc1 !== 16'hFFFF || fc3 !== 16'hFFFF) begin
         errors++;
         $display("FAIL count_saturate: got %h, required ffff", fc1);
      end
   endtask

   task automatic test_reset_inflight();
      logic seen;
      drive(32'h1000_0000, 1'b1, 4'h0);
      drive(32'hFF00_0000, 1'b1, 4'h0);
      @(posedge clk);
      #1;
      reset_i = 1'b0;
      addr = '0; rd = 1'b0; wm = '0; clr = 1'b0;
      #1;
      checks++;
      if ({rvld1, rdata1, rvld3, rdata3, f1, fa1, fw1, fc1} !== '0) begin
         errors++;
         $display("FAIL reset_inflight_outputs: vld1 %b d1 %h vld3 %b d3 %h fault %b addr %h wr %b cnt %h, required all 0",
                  rvld1, rdata1, rvld3, rdata3, f1, fa1, fw1, fc1);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_i = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         seen = seen | rvld1 | rvld3;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL reset_inflight_valid: got %b, required 0", seen);
      end
   endtask

   initial begin
      reset_i = 1'b1;
      addr = '0; rd = 1'b0; wm = '0; clr = 1'b0;
      dev_rd[0] = 32'hB105_0000;
      dev_rd[1] = 32'hDEAD_BEEF;
      dev_rd[2] = 32'h5EA0_0002;
      dev_rd[3] = 32'hD15B_0003;
      dev_rd[4] = 32'h5A17_0004;
      dev_rd[5] = 32'hCAFE_0005;
      #2 reset_i = 1'b0;
      test_reset();
      test_read_lat1();
      test_write_mask();
      test_back_to_back();
      test_unmapped();
      test_clear_collision();
      test_reset_inflight();
      repeat (5) drive(32'h0, 1'b0, 4'h0);
      checks++;
      if (q1.size() != 0 || q3.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d/%0d reads outstanding, required 0/0", q1.size(), q3.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
